vga_sobel_reader: RTL and testbench

- Display-side counterpart of the Sobel edge path. The Sobel stage writes 16-bit pixels through sdram_wr_en/sdram_wr_data into the SDRAM write FIFO; this block pulls them back out of the SDRAM read FIFO.
- Generates 640x480@60 VGA timing, issues read requests exactly H_VALID x V_VALID times per frame, and drives RGB565 pixels to the VGA DAC pins.
- Sits between the SDRAM controller read FIFO (normal mode, q registered, 1-cycle read latency) and the VGA connector, in the pixel-clock domain.

---
 rtl/vga_pkg.sv | 21 ++
 rtl/vga_timing_gen.sv | 66 ++++++
 rtl/vga_sobel_reader.sv | 117 +++++++++++
 tb/tb_vga_sobel_reader.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared 640x480@60 timing constants, pixel format and pipeline depth
package vga_pkg;

  localparam int H_SYNC_DEF  = 96;
  localparam int H_BACK_DEF  = 48;
  localparam int H_VALID_DEF = 640;
  localparam int H_FRONT_DEF = 16;
  localparam int V_SYNC_DEF  = 2;
  localparam int V_BACK_DEF  = 33;
  localparam int V_VALID_DEF = 480;
  localparam int V_FRONT_DEF = 10;

  localparam int RGB_R_W = 5;
  localparam int RGB_G_W = 6;
  localparam int RGB_B_W = 5;
  localparam int PIX_W   = RGB_R_W + RGB_G_W + RGB_B_W;

  localparam int CNT_W    = 12;
  localparam int PIPE_LAT = 3;

endpackage

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - horizontal/vertical counters and stage-0 timing decode
// Ports: clk, rst_n (async, active low), en (0 forces counters to 0);
//        hs0/vs0 raw sync terms, act0 active-video term, fs0 first position of a frame.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_SYNC  = H_SYNC_DEF,
  parameter int H_BACK  = H_BACK_DEF,
  parameter int H_VALID = H_VALID_DEF,
  parameter int H_FRONT = H_FRONT_DEF,
  parameter int V_SYNC  = V_SYNC_DEF,
  parameter int V_BACK  = V_BACK_DEF,
  parameter int V_VALID = V_VALID_DEF,
  parameter int V_FRONT = V_FRONT_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic hs0,
  output logic vs0,
  output logic act0,
  output logic fs0
);

  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_SYNC + H_BACK + H_VALID + H_FRONT - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_SYNC + V_BACK + V_VALID + V_FRONT - 1);
  localparam logic [CNT_W-1:0] H_SYNC_E = CNT_W'(H_SYNC);
  localparam logic [CNT_W-1:0] V_SYNC_E = CNT_W'(V_SYNC);
  localparam logic [CNT_W-1:0] H_ACT_LO = CNT_W'(H_SYNC + H_BACK);
  localparam logic [CNT_W-1:0] H_ACT_HI = CNT_W'(H_SYNC + H_BACK + H_VALID);
  localparam logic [CNT_W-1:0] V_ACT_LO = CNT_W'(V_SYNC + V_BACK);
  localparam logic [CNT_W-1:0] V_ACT_HI = CNT_W'(V_SYNC + V_BACK + V_VALID);

  logic [CNT_W-1:0] cnt_h_q, cnt_h_d;
  logic [CNT_W-1:0] cnt_v_q, cnt_v_d;

  always_comb begin
    cnt_h_d = cnt_h_q + 1'b1;
    cnt_v_d = cnt_v_q;
    if (!en) begin
      // Disabled: abandon the frame so the next one starts clean at 0/0.
      cnt_h_d = '0;
      cnt_v_d = '0;
    end else if (cnt_h_q == H_LAST) begin
      cnt_h_d = '0;
      cnt_v_d = (cnt_v_q == V_LAST) ? '0 : cnt_v_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_h_q <= '0;
      cnt_v_q <= '0;
    end else begin
      cnt_h_q <= cnt_h_d;
      cnt_v_q <= cnt_v_d;
    end
  end

  assign hs0  = (cnt_h_q < H_SYNC_E);
  assign vs0  = (cnt_v_q < V_SYNC_E);
  assign act0 = en && (cnt_h_q >= H_ACT_LO) && (cnt_h_q < H_ACT_HI)
                   && (cnt_v_q >= V_ACT_LO) && (cnt_v_q < V_ACT_HI);
  assign fs0  = en && (cnt_h_q == '0) && (cnt_v_q == '0);

endmodule

// File: rtl/vga_sobel_reader.sv
// rtl/vga_sobel_reader.sv - VGA timing plus SDRAM read-FIFO pixel fetch for the Sobel display path
// Ports: clk, rst_n (async, active low), en (display enable);
//        sdram_rd_empty/sdram_rd_data from the read FIFO (1-cycle q latency), sdram_rd_en request;
//        vga_hsync/vga_vsync (active low), vga_de, vga_rgb (RGB565), frame_start pulse,
//        underflow (sticky until the next frame_start).
module vga_sobel_reader
  import vga_pkg::*;
#(
  parameter int H_SYNC  = H_SYNC_DEF,
  parameter int H_BACK  = H_BACK_DEF,
  parameter int H_VALID = H_VALID_DEF,
  parameter int H_FRONT = H_FRONT_DEF,
  parameter int V_SYNC  = V_SYNC_DEF,
  parameter int V_BACK  = V_BACK_DEF,
  parameter int V_VALID = V_VALID_DEF,
  parameter int V_FRONT = V_FRONT_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             sdram_rd_empty,
  input  logic [PIX_W-1:0] sdram_rd_data,
  output logic             sdram_rd_en,
  output logic             vga_hsync,
  output logic             vga_vsync,
  output logic             vga_de,
  output logic [PIX_W-1:0] vga_rgb,
  output logic             frame_start,
  output logic             underflow
);

  logic hs0, vs0, act0, fs0;

  vga_timing_gen #(
    .H_SYNC (H_SYNC),  .H_BACK (H_BACK),  .H_VALID(H_VALID), .H_FRONT(H_FRONT),
    .V_SYNC (V_SYNC),  .V_BACK (V_BACK),  .V_VALID(V_VALID), .V_FRONT(V_FRONT)
  ) u_timing (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (en),
    .hs0  (hs0),
    .vs0  (vs0),
    .act0 (act0),
    .fs0  (fs0)
  );

  // act1 doubles as the FIFO request: the read issued in stage 1 returns q in stage 2.
  logic hs1_q, vs1_q, act1_q, fs1_q;
  logic hs1_d, vs1_d, act1_d, fs1_d;
  logic hs2_q, vs2_q, act2_q, fs2_q;
  logic hs2_d, vs2_d, act2_d, fs2_d;
  logic             hsync_q, vsync_q, de_q, fs_q, uf_q;
  logic             hsync_d, vsync_d, de_d, fs_d, uf_d;
  logic [PIX_W-1:0] rgb_q, rgb_d;

  always_comb begin
    hs1_d   = hs0;
    vs1_d   = vs0;
    act1_d  = act0;
    fs1_d   = fs0;
    hs2_d   = hs1_q;
    vs2_d   = vs1_q;
    act2_d  = act1_q;
    fs2_d   = fs1_q;
    hsync_d = ~hs2_q;
    vsync_d = ~vs2_q;
    de_d    = act2_q;
    fs_d    = fs2_q;
    // Stale q is shown on an underflowed pixel; no substitution.
    rgb_d   = act2_q ? sdram_rd_data : '0;
    // fs2 clears so underflow reads 0 alongside frame_start; a same-edge set wins.
    uf_d    = (act1_q && sdram_rd_empty) || (uf_q && !fs2_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hs1_q   <= 1'b0;
      vs1_q   <= 1'b0;
      act1_q  <= 1'b0;
      fs1_q   <= 1'b0;
      hs2_q   <= 1'b0;
      vs2_q   <= 1'b0;
      act2_q  <= 1'b0;
      fs2_q   <= 1'b0;
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
      de_q    <= 1'b0;
      fs_q    <= 1'b0;
      uf_q    <= 1'b0;
      rgb_q   <= '0;
    end else begin
      hs1_q   <= hs1_d;
      vs1_q   <= vs1_d;
      act1_q  <= act1_d;
      fs1_q   <= fs1_d;
      hs2_q   <= hs2_d;
      vs2_q   <= vs2_d;
      act2_q  <= act2_d;
      fs2_q   <= fs2_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      de_q    <= de_d;
      fs_q    <= fs_d;
      uf_q    <= uf_d;
      rgb_q   <= rgb_d;
    end
  end

  assign sdram_rd_en = act1_q;
  assign vga_hsync   = hsync_q;
  assign vga_vsync   = vsync_q;
  assign vga_de      = de_q;
  assign vga_rgb     = rgb_q;
  assign frame_start = fs_q;
  assign underflow   = uf_q;

endmodule

// File: tb/tb_vga_sobel_reader.sv
// tb/tb_vga_sobel_reader.sv - randomized bench for vga_sobel_reader against a frame-position model
module tb_vga_sobel_reader;

  localparam int P_H_SYNC  = 2;
  localparam int P_H_BACK  = 2;
  localparam int P_H_VALID = 4;
  localparam int P_H_FRONT = 2;
  localparam int P_V_SYNC  = 1;
  localparam int P_V_BACK  = 1;
  localparam int P_V_VALID = 3;
  localparam int P_V_FRONT = 1;
  localparam int HT = P_H_SYNC + P_H_BACK + P_H_VALID + P_H_FRONT;
  localparam int VT = P_V_SYNC + P_V_BACK + P_V_VALID + P_V_FRONT;
  localparam int HA = P_H_SYNC + P_H_BACK;
  localparam int VA = P_V_SYNC + P_V_BACK;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        sdram_rd_empty;
  logic [15:0] sdram_rd_data;
  logic        sdram_rd_en;
  logic        vga_hsync, vga_vsync, vga_de, frame_start, underflow;
  logic [15:0] vga_rgb;

  vga_sobel_reader #(
    .H_SYNC(P_H_SYNC), .H_BACK(P_H_BACK), .H_VALID(P_H_VALID), .H_FRONT(P_H_FRONT),
    .V_SYNC(P_V_SYNC), .V_BACK(P_V_BACK), .V_VALID(P_V_VALID), .V_FRONT(P_V_FRONT)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .en            (en),
    .sdram_rd_empty(sdram_rd_empty),
    .sdram_rd_data (sdram_rd_data),
    .sdram_rd_en   (sdram_rd_en),
    .vga_hsync     (vga_hsync),
    .vga_vsync     (vga_vsync),
    .vga_de        (vga_de),
    .vga_rgb       (vga_rgb),
    .frame_start   (frame_start),
    .underflow     (underflow)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  // Model: frame position since the last enable/reset, and the timing terms of the
  // last three positions (index 0 newest). Outputs show the oldest, the request the newest.
  typedef struct packed {
    logic hs;
    logic vs;
    logic act;
    logic fs;
  } pos_t;

  pos_t        hist [3];
  int          pos;
  int          model_cnt;
  logic [15:0] pixq [$];
  logic        exp_rd, exp_hs, exp_vs, exp_de, exp_fs, exp_uf;
  logic [15:0] exp_rgb;
  int          fifo_cnt;

  task automatic model_reset();
    for (int i = 0; i < 3; i++) hist[i] = '0;
    pos = 0;
    pixq.delete();
    exp_rd = 0; exp_hs = 1; exp_vs = 1; exp_de = 0; exp_fs = 0; exp_uf = 0; exp_rgb = '0;
  endtask

  task automatic model_step(input bit en_i, input bit empty_i);
    pos_t s0;
    int   h;
    int   v;
    bit   prev_rd;
    bit   uf_set;
    h       = pos % HT;
    v       = pos / HT;
    s0.hs   = (h < P_H_SYNC);
    s0.vs   = (v < P_V_SYNC);
    s0.act  = en_i && h >= HA && h < HA + P_H_VALID && v >= VA && v < VA + P_V_VALID;
    s0.fs   = en_i && pos == 0;
    pos     = en_i ? (pos + 1) % (HT * VT) : 0;
    prev_rd = hist[0].act;
    uf_set  = prev_rd && empty_i;
    if (prev_rd) begin
      if (!empty_i) model_cnt++;
      pixq.push_back(model_cnt[15:0]);
    end
    hist[2] = hist[1];
    hist[1] = hist[0];
    hist[0] = s0;
    exp_rd  = s0.act;
    exp_hs  = ~hist[2].hs;
    exp_vs  = ~hist[2].vs;
    exp_de  = hist[2].act;
    exp_fs  = hist[2].fs;
    exp_rgb = '0;
    if (hist[2].act && pixq.size() > 0) exp_rgb = pixq.pop_front();
    exp_uf  = uf_set || (exp_uf && !hist[2].fs);
  endtask

  task automatic check_all(input string where);
    chk({where, ":rd_en"},       32'(sdram_rd_en), 32'(exp_rd));
    chk({where, ":hsync"},       32'(vga_hsync),   32'(exp_hs));
    chk({where, ":vsync"},       32'(vga_vsync),   32'(exp_vs));
    chk({where, ":de"},          32'(vga_de),      32'(exp_de));
    chk({where, ":rgb"},         32'(vga_rgb),     32'(exp_rgb));
    chk({where, ":frame_start"}, 32'(frame_start), 32'(exp_fs));
    chk({where, ":underflow"},   32'(underflow),   32'(exp_uf));
  endtask

  // Called #1 after an edge; inputs change here, then one clock elapses.
  task automatic step(input bit en_i, input bit empty_i);
    bit pre_rd;
    en             = en_i;
    sdram_rd_empty = empty_i;
    pre_rd         = sdram_rd_en;
    @(posedge clk);
    #1;
    if (pre_rd && !empty_i) begin
      fifo_cnt++;
      sdram_rd_data = fifo_cnt[15:0];
    end
    model_step(en_i, empty_i);
    check_all("run");
  endtask

  // Mid-cycle asynchronous reset pulse.
  task automatic pulse_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("rst_async");
    @(posedge clk);
    #1;
    check_all("rst_hold");
    rst_n = 1'b1;
  endtask

  initial begin
    int en_low;
    bit cur_en;
    bit cur_empty;
    rst_n          = 1'b0;
    en             = 1'b0;
    sdram_rd_empty = 1'b0;
    sdram_rd_data  = '0;
    fifo_cnt       = 0;
    model_cnt      = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("por");
    rst_n = 1'b1;

    // Two clean frames with a never-empty FIFO.
    for (int i = 0; i < 2 * HT * VT; i++) step(1'b1, 1'b0);

    // Drop en mid-line 2 of a frame for 20 clocks.
    while (pos != 2 * HT + 5) step(1'b1, 1'b0);
    for (int i = 0; i < 20; i++) step(1'b0, 1'b0);
    for (int i = 0; i < HT * VT + 5; i++) step(1'b1, 1'b0);

    // Randomized enables, empty flags and reset pulses.
    en_low = 0;
    for (int i = 0; i < 4000; i++) begin
      if (en_low > 0) begin
        en_low--;
      end else if ($urandom_range(0, 199) == 0) begin
        en_low = $urandom_range(5, 30);
      end
      cur_en    = (en_low == 0);
      cur_empty = ($urandom_range(0, 11) == 0);
      if ($urandom_range(0, 799) == 0) pulse_reset();
      step(cur_en, cur_empty);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
